utlb_trans: RTL

UTLB_TRANS -- requirements
Module: utlb_trans

---
 rtl/utlb_trans_pkg.sv | 86 ++++++++
 rtl/utlb_array.sv | 99 +++++++++
 rtl/utlb_trans.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/utlb_trans_pkg.sv
// Shared definitions for the micro-TLB translation block.
// Holds the CSR direct-map window layout, the main-TLB search result,
// the stored micro-TLB entry format, the response bundle and the FSM
// state encoding, plus a helper that turns a TLB lookup result into a
// response (physical tag, memory type and exception flags).
package utlb_trans_pkg;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REFILL,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [2:0] vseg;
        logic [2:0] pseg;
        logic [1:0] mat;
        logic       plv3;
        logic       plv0;
    } dmw_t;

    typedef struct packed {
        logic        found;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  mat;
        logic        v;
        logic        d;
        logic [1:0]  plv;
        logic        g;
    } tlb_result_t;

    // Page attributes that both a hit and a refill feed into the response.
    typedef struct packed {
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  mat;
        logic        v;
        logic        d;
        logic [1:0]  plv;
    } tlb_attr_t;

    typedef struct packed {
        logic        valid;
        logic [19:0] vtag;
        logic [9:0]  asid;
        logic        g;
        tlb_attr_t   attr;
    } utlb_entry_t;

    typedef struct packed {
        logic [19:0] ptag;
        logic [1:0]  mat;
        logic        page_fault;
        logic        page_invalid;
        logic        page_dirty;
        logic        plv_fault;
    } resp_t;

    // An invalid page reports only page_invalid; dirty and privilege
    // faults are meaningless for it and are suppressed.
    function automatic resp_t tlb_resp(input logic        found,
                                       input tlb_attr_t   a,
                                       input logic [19:0] vtag,
                                       input logic        store,
                                       input logic [1:0]  cur_plv);
        resp_t r;
        r = '0;
        if (!found) begin
            r.ptag       = vtag;
            r.page_fault = 1'b1;
        end else begin
            r.ptag         = (a.ps == PS_2M) ? {a.ppn[19:9], vtag[8:0]} : a.ppn;
            r.mat          = a.mat;
            r.page_invalid = !a.v;
            r.page_dirty   = a.v && store && !a.d;
            r.plv_fault    = a.v && (cur_plv > a.plv);
        end
        return r;
    endfunction

endpackage

// File: rtl/utlb_array.sv
// Micro-TLB entry storage with fully parallel match and victim choice.
// Ports:
//   clk, resetn            clock and asynchronous active-low reset
//   flush                  clears every valid bit; beats a same-cycle fill
//   lookup_vtag/asid       search key, lookup_hit/lookup_attr the result
//   fill_en/vtag/asid/data write a main-TLB result (only if data.found)
module utlb_array
    import utlb_trans_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [19:0] lookup_vtag,
    input  logic [9:0]  lookup_asid,
    output logic        lookup_hit,
    output tlb_attr_t   lookup_attr,
    input  logic        fill_en,
    input  logic [19:0] fill_vtag,
    input  logic [9:0]  fill_asid,
    input  tlb_result_t fill_data
);

    localparam int PTR_W = $clog2(ENTRIES);

    utlb_entry_t        entries [ENTRIES];
    logic [ENTRIES-1:0] match;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   victim;
    logic               victim_found;
    utlb_entry_t        fill_entry;

    // A 2M page only compares the upper tag bits; fills never create
    // overlapping entries, so at most one bit of match is set.
    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = entries[i].valid &&
                       (entries[i].g || (entries[i].asid == lookup_asid)) &&
                       ((entries[i].attr.ps == PS_2M) ?
                            (entries[i].vtag[19:9] == lookup_vtag[19:9]) :
                            (entries[i].vtag == lookup_vtag));
        end
    end

    always_comb begin
        lookup_hit  = |match;
        lookup_attr = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (match[i]) begin
                lookup_attr = entries[i].attr;
            end
        end
    end

    // Prefer the lowest free slot; only evict via round-robin when full.
    always_comb begin
        victim       = rr_ptr;
        victim_found = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!entries[i].valid && !victim_found) begin
                victim       = PTR_W'(i);
                victim_found = 1'b1;
            end
        end
    end

    always_comb begin
        fill_entry           = '0;
        fill_entry.valid     = 1'b1;
        fill_entry.vtag      = fill_vtag;
        fill_entry.asid      = fill_asid;
        fill_entry.g         = fill_data.g;
        fill_entry.attr.ppn  = fill_data.ppn;
        fill_entry.attr.ps   = fill_data.ps;
        fill_entry.attr.mat  = fill_data.mat;
        fill_entry.attr.v    = fill_data.v;
        fill_entry.attr.d    = fill_data.d;
        fill_entry.attr.plv  = fill_data.plv;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
            rr_ptr <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (fill_en && fill_data.found) begin
            entries[victim] <= fill_entry;
            rr_ptr          <= rr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/utlb_trans.sv
// Micro-TLB address translation front end.
// Accepts one virtual tag at a time (req_*), resolves it through direct
// address mode, the two direct map windows or the micro-TLB, refills
// from the main TLB (tlb_s_*) on a miss, and holds the result on resp_*
// until the consumer takes it.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   direct_access(_mat), plv,    CSR state sampled in the CHECK cycle
//   asid, dmw0, dmw1
//   flush                        invalidate every micro-TLB entry
//   req_valid/ready/vtag/store   request handshake
//   resp_valid/ready/ptag/mat    response handshake and data
//   resp_page_*/resp_plv_fault   exception flags
//   tlb_s_*                      main-TLB search request and result
module utlb_trans
    import utlb_trans_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        direct_access,
    input  logic [1:0]  direct_access_mat,
    input  logic [1:0]  plv,
    input  logic [9:0]  asid,
    input  dmw_t        dmw0,
    input  dmw_t        dmw1,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_vtag,
    input  logic        req_store,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [19:0] resp_ptag,
    output logic [1:0]  resp_mat,
    output logic        resp_page_fault,
    output logic        resp_page_invalid,
    output logic        resp_page_dirty,
    output logic        resp_plv_fault,
    output logic        tlb_s_req,
    output logic [18:0] tlb_s_vppn,
    output logic        tlb_s_va_bit12,
    output logic [9:0]  tlb_s_asid,
    input  logic        tlb_s_resp_valid,
    input  tlb_result_t tlb_s_result
);

    state_t      state;
    logic [19:0] vtag_q;
    logic        store_q;
    resp_t       resp_q;

    logic        lookup_hit;
    tlb_attr_t   lookup_attr;
    tlb_attr_t   refill_attr;
    logic        fill_en;
    logic        dmw0_hit;
    logic        dmw1_hit;
    resp_t       tlb_path;
    resp_t       check_resp;
    logic        check_done;

    utlb_array #(
        .ENTRIES (ENTRIES)
    ) u_array (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .lookup_vtag (vtag_q),
        .lookup_asid (asid),
        .lookup_hit  (lookup_hit),
        .lookup_attr (lookup_attr),
        .fill_en     (fill_en),
        .fill_vtag   (vtag_q),
        .fill_asid   (asid),
        .fill_data   (tlb_s_result)
    );

    assign req_ready      = (state == S_IDLE);
    assign resp_valid     = (state == S_RESP);
    assign tlb_s_req      = (state == S_REFILL);
    assign tlb_s_vppn     = vtag_q[19:1];
    assign tlb_s_va_bit12 = vtag_q[0];
    assign tlb_s_asid     = asid;
    assign fill_en        = (state == S_REFILL) && tlb_s_resp_valid;

    assign resp_ptag         = resp_q.ptag;
    assign resp_mat          = resp_q.mat;
    assign resp_page_fault   = resp_q.page_fault;
    assign resp_page_invalid = resp_q.page_invalid;
    assign resp_page_dirty   = resp_q.page_dirty;
    assign resp_plv_fault    = resp_q.plv_fault;

    // Windows are enabled per privilege level; only PLV0 and PLV3 exist.
    assign dmw0_hit = (vtag_q[19:17] == dmw0.vseg) &&
                      (((plv == 2'd0) && dmw0.plv0) || ((plv == 2'd3) && dmw0.plv3));
    assign dmw1_hit = (vtag_q[19:17] == dmw1.vseg) &&
                      (((plv == 2'd0) && dmw1.plv0) || ((plv == 2'd3) && dmw1.plv3));

    // The same flag logic serves a micro-TLB hit (CHECK) and a main-TLB
    // answer (REFILL); the state picks which attributes feed it.
    always_comb begin
        refill_attr     = '0;
        refill_attr.ppn = tlb_s_result.ppn;
        refill_attr.ps  = tlb_s_result.ps;
        refill_attr.mat = tlb_s_result.mat;
        refill_attr.v   = tlb_s_result.v;
        refill_attr.d   = tlb_s_result.d;
        refill_attr.plv = tlb_s_result.plv;
        if (state == S_REFILL) begin
            tlb_path = tlb_resp(tlb_s_result.found, refill_attr, vtag_q, store_q, plv);
        end else begin
            tlb_path = tlb_resp(lookup_hit, lookup_attr, vtag_q, store_q, plv);
        end
    end

    // Translation priority: direct address, DMW0, DMW1, then micro-TLB.
    always_comb begin
        check_resp = '0;
        check_done = 1'b1;
        if (direct_access) begin
            check_resp.ptag = vtag_q;
            check_resp.mat  = direct_access_mat;
        end else if (dmw0_hit) begin
            check_resp.ptag = {dmw0.pseg, vtag_q[16:0]};
            check_resp.mat  = dmw0.mat;
        end else if (dmw1_hit) begin
            check_resp.ptag = {dmw1.pseg, vtag_q[16:0]};
            check_resp.mat  = dmw1.mat;
        end else begin
            check_resp = tlb_path;
            check_done = lookup_hit;
        end
    end

    // Request sequencer; flush only touches the entry array, never this.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            vtag_q  <= '0;
            store_q <= 1'b0;
            resp_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        vtag_q  <= req_vtag;
                        store_q <= req_store;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (check_done) begin
                        resp_q <= check_resp;
                        state  <= S_RESP;
                    end else begin
                        state  <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (tlb_s_resp_valid) begin
                        resp_q <= tlb_path;
                        state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
